// File: rtl/uart_tx_param_if.sv
// Ready/valid word handshake between a producer and the UART transmitter FIFO.
interface uart_tx_param_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/uart_tx_param.sv
// Buffered UART transmitter: small FIFO feeding a frame serialiser with
// run-time baud divisor, parity mode and stop-bit count latched per frame.
module uart_tx_param #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned FIFO_AW = 2
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [DIV_W-1:0]   baud_div,
  input  logic [1:0]         parity_mode,
  input  logic               stop2,
  uart_tx_param_if.slave     bus,
  output logic               Rs232_Tx,
  output logic               Tx_Done,
  output logic               uart_state,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned BW    = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]       count_nxt;
  logic                push, pop, tick, last_stop;
  logic [DIV_W-1:0]    timer, div_q;
  logic                par_en_q, par_bit_q, stop2_q, stop_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [DATA_W-1:0]   shreg;

  // Launch a frame from IDLE, or chain straight into the next one at the end of the last stop period.
  always_comb begin
    push      = bus.data_valid && bus.data_ready;
    tick      = (timer == div_q);
    last_stop = tick && (stop_cnt == stop2_q);
    pop       = (fifo_count != '0) && ((state == IDLE) || ((state == STOP) && last_stop));
    count_nxt = fifo_count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      bus.data_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      fifo_count     <= count_nxt;
      bus.data_ready <= (count_nxt < CW'(DEPTH));
    end
  end

  // Frame sequencer; every output is a flop so the line never glitches.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      Rs232_Tx   <= 1'b1;
      Tx_Done    <= 1'b0;
      uart_state <= 1'b0;
      timer      <= '0;
      div_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt   <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
    end else begin
      Tx_Done <= (state == STOP) && last_stop;
      if (pop) begin
        shreg      <= mem[rd_ptr];
        div_q      <= baud_div;
        par_en_q   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
        par_bit_q  <= (^mem[rd_ptr]) ^ (parity_mode == 2'b10);
        stop2_q    <= stop2;
        timer      <= '0;
        Rs232_Tx   <= 1'b0;
        uart_state <= 1'b1;
        state      <= START;
      end else if ((state != IDLE) && !tick) begin
        timer <= timer + DIV_W'(1);
      end else begin
        timer <= '0;
        case (state)
          IDLE: begin
            Rs232_Tx   <= 1'b1;
            uart_state <= 1'b0;
          end
          START: begin
            Rs232_Tx <= shreg[0];
            shreg    <= shreg >> 1;
            bit_cnt  <= '0;
            state    <= DATA;
          end
          DATA: begin
            if (bit_cnt == BW'(DATA_W - 1)) begin
              if (par_en_q) begin
                Rs232_Tx <= par_bit_q;
                state    <= PARITY;
              end else begin
                Rs232_Tx <= 1'b1;
                stop_cnt <= 1'b0;
                state    <= STOP;
              end
            end else begin
              Rs232_Tx <= shreg[0];
              shreg    <= shreg >> 1;
              bit_cnt  <= bit_cnt + BW'(1);
            end
          end
          PARITY: begin
            Rs232_Tx <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
          STOP: begin
            if (stop_cnt == stop2_q) begin
              Rs232_Tx   <= 1'b1;
              uart_state <= 1'b0;
              state      <= IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: 8-bit and 7-bit instances compared
// cycle by cycle against an expected line waveform built from frame rules.
module tb_uart_tx_param;

  typedef struct {
    logic [8:0] data;
    int         div;
    logic [1:0] pm;
    logic       s2;
  } frame_t;
  typedef bit bitq_t[$];

  logic        Clk;
  logic        Rst_n;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic        tx8, done8, st8, tx7, done7, st7;
  logic [2:0]  cnt8, cnt7;
  int          n_cmp = 0;
  int          n_err = 0;

  uart_tx_param_if #(.DATA_W(8)) bus8 ();
  uart_tx_param_if #(.DATA_W(7)) bus7 ();

  uart_tx_param #(.DATA_W(8), .DIV_W(16), .FIFO_AW(2)) u_dut8 (
    .Clk(Clk), .Rst_n(Rst_n), .baud_div(baud_div), .parity_mode(parity_mode),
    .stop2(stop2), .bus(bus8), .Rs232_Tx(tx8), .Tx_Done(done8),
    .uart_state(st8), .fifo_count(cnt8)
  );

  uart_tx_param #(.DATA_W(7), .DIV_W(16), .FIFO_AW(2)) u_dut7 (
    .Clk(Clk), .Rst_n(Rst_n), .baud_div(baud_div), .parity_mode(parity_mode),
    .stop2(stop2), .bus(bus7), .Rs232_Tx(tx7), .Tx_Done(done7),
    .uart_state(st7), .fifo_count(cnt7)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic get_tx(int w);   return (w == 0) ? tx8 : tx7;     endfunction
  function automatic logic get_done(int w); return (w == 0) ? done8 : done7; endfunction
  function automatic logic get_st(int w);   return (w == 0) ? st8 : st7;     endfunction
  function automatic logic [2:0] get_cnt(int w); return (w == 0) ? cnt8 : cnt7; endfunction
  function automatic logic get_rdy(int w);
    return (w == 0) ? bus8.data_ready : bus7.data_ready;
  endfunction

  function automatic frame_t mk(logic [8:0] d, int dv, logic [1:0] pm, logic s2);
    frame_t f;
    f.data = d; f.div = dv; f.pm = pm; f.s2 = s2;
    return f;
  endfunction

  // Reference: start, data LSB first, optional parity, one or two stops.
  function automatic bitq_t frame_bits(frame_t f, int dw);
    bitq_t q;
    bit    p;
    p = 1'b0;
    q.push_back(1'b0);
    for (int i = 0; i < dw; i++) begin
      q.push_back(f.data[i]);
      p ^= f.data[i];
    end
    if (f.pm == 2'b01) q.push_back(p);
    if (f.pm == 2'b10) q.push_back(~p);
    q.push_back(1'b1);
    if (f.s2) q.push_back(1'b1);
    return q;
  endfunction

  task automatic drive(int w, logic v, logic [8:0] d);
    if (w == 0) begin bus8.data_valid = v; bus8.data_in = d[7:0]; end
    else        begin bus7.data_valid = v; bus7.data_in = d[6:0]; end
  endtask

  task automatic push_words(int w, logic [8:0] words[$]);
    int t;
    foreach (words[i]) begin
      @(negedge Clk);
      drive(w, 1'b1, words[i]);
      t = 0;
      while (!get_rdy(w) && t < 500) begin @(negedge Clk); t++; end
      if (t >= 500) begin
        n_cmp++; n_err++;
        $display("FAIL push_ready dut%0d: data_ready stayed 0, required 1 within 500 clocks", w);
      end
      @(posedge Clk);
    end
    @(negedge Clk);
    drive(w, 1'b0, 9'h0);
  endtask

  task automatic check_frames(int w, frame_t fq[$]);
    int    t, bad, cyc;
    bitq_t bits;
    logic  ot, od, os, et, ed;
    t = 0;
    @(negedge Clk);
    while (get_tx(w) !== 1'b0 && t < 3000) begin @(negedge Clk); t++; end
    if (t >= 3000) begin
      n_cmp++; n_err++;
      $display("FAIL start_wait dut%0d: line never fell, required a start bit within 3000 clocks", w);
      return;
    end
    foreach (fq[k]) begin
      bits = frame_bits(fq[k], (w == 0) ? 8 : 7);
      bad = -1; cyc = 0; ot = 0; od = 0; os = 0; et = 0; ed = 0;
      foreach (bits[b]) begin
        for (int r = 0; r <= fq[k].div; r++) begin
          if (bad < 0 && (get_tx(w) !== bits[b] || get_done(w) !== logic'(cyc == 0 && k > 0)
                          || get_st(w) !== 1'b1)) begin
            bad = cyc; ot = get_tx(w); od = get_done(w); os = get_st(w);
            et = bits[b]; ed = logic'(cyc == 0 && k > 0);
          end
          @(negedge Clk);
          cyc++;
        end
      end
      n_cmp++;
      if (bad >= 0) begin
        n_err++;
        $display("FAIL frame dut%0d #%0d data=%h: cycle %0d tx/done/state=%b%b%b, required %b%b1",
                 w, k, fq[k].data, bad, ot, od, os, et, ed);
      end
    end
    n_cmp++;
    if ({get_tx(w), get_done(w), get_st(w)} !== 3'b110) begin
      n_err++;
      $display("FAIL frame_end dut%0d: tx/done/state=%b%b%b, required 110",
               w, get_tx(w), get_done(w), get_st(w));
    end
    @(negedge Clk);
    n_cmp++;
    if (get_done(w) !== 1'b0) begin
      n_err++;
      $display("FAIL done_width dut%0d: Tx_Done=%b one cycle later, required 0", w, get_done(w));
    end
  endtask

  task automatic set_cfg(int dv, logic [1:0] pm, logic s2);
    baud_div = 16'(dv); parity_mode = pm; stop2 = s2;
  endtask

  task automatic test_reset;
    Rst_n = 1'b0;
    drive(0, 1'b0, 9'h0); drive(1, 1'b0, 9'h0);
    set_cfg(4, 2'b00, 1'b0);
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    for (int w = 0; w < 2; w++) begin
      n_cmp++;
      if ({get_tx(w), get_done(w), get_st(w), get_rdy(w), get_cnt(w)} !== 7'b1001_000) begin
        n_err++;
        $display("FAIL reset_values dut%0d: tx/done/state/ready/count=%b%b%b%b/%0d, required 1001/0",
                 w, get_tx(w), get_done(w), get_st(w), get_rdy(w), get_cnt(w));
      end
    end
  endtask

  task automatic test_8n1_latency;
    frame_t q[$];
    set_cfg(4, 2'b00, 1'b0);
    @(negedge Clk);
    drive(0, 1'b1, 9'h055);
    @(posedge Clk); #1;
    drive(0, 1'b0, 9'h0);
    n_cmp++;
    if (cnt8 !== 3'd1 || tx8 !== 1'b1) begin
      n_err++;
      $display("FAIL latency_e count/tx=%0d/%b, required 1/1", cnt8, tx8);
    end
    @(posedge Clk); #1;
    n_cmp++;
    if (cnt8 !== 3'd0 || tx8 !== 1'b0 || st8 !== 1'b1) begin
      n_err++;
      $display("FAIL latency_e1 count/tx/state=%0d/%b/%b, required 0/0/1", cnt8, tx8, st8);
    end
    q.push_back(mk(9'h055, 4, 2'b00, 1'b0));
    check_frames(0, q);
  endtask

  task automatic test_parity7;
    frame_t q[$];
    logic [8:0] w[$];
    w.push_back(9'h041);
    for (int m = 1; m <= 2; m++) begin
      set_cfg(0, 2'(m), 1'b1);
      q.delete();
      q.push_back(mk(9'h041, 0, 2'(m), 1'b1));
      fork
        push_words(1, w);
        check_frames(1, q);
      join
    end
  endtask

  task automatic test_back_to_back;
    frame_t q[$];
    int acc;
    set_cfg(9, 2'b00, 1'b0);
    for (int i = 1; i <= 5; i++) q.push_back(mk(9'(i), 9, 2'b00, 1'b0));
    acc = 0;
    fork
      check_frames(0, q);
      begin
        for (int i = 1; i <= 6; i++) begin
          @(negedge Clk);
          drive(0, 1'b1, 9'(i));
          if (bus8.data_ready) acc++;
        end
        @(negedge Clk);
        n_cmp++;
        if (acc != 5 || cnt8 !== 3'd4 || bus8.data_ready !== 1'b0) begin
          n_err++;
          $display("FAIL fifo_full accepted/count/ready=%0d/%0d/%b, required 5/4/0",
                   acc, cnt8, bus8.data_ready);
        end
        drive(0, 1'b0, 9'h0);
      end
    join
  endtask

  task automatic test_push_pop;
    frame_t q[$];
    logic [8:0] w[$];
    int t;
    set_cfg(1, 2'b00, 1'b0);
    w.push_back(9'h0A1); w.push_back(9'h0B2);
    q.push_back(mk(9'h0A1, 1, 2'b00, 1'b0));
    q.push_back(mk(9'h0B2, 1, 2'b00, 1'b0));
    q.push_back(mk(9'h0C3, 1, 2'b00, 1'b0));
    fork
      push_words(0, w);
      check_frames(0, q);
      begin
        t = 0;
        @(negedge Clk);
        while (tx8 !== 1'b0 && t < 100) begin @(negedge Clk); t++; end
        repeat (19) @(negedge Clk);
        drive(0, 1'b1, 9'h0C3);
        n_cmp++;
        if (cnt8 !== 3'd1) begin
          n_err++;
          $display("FAIL pushpop_before count=%0d, required 1", cnt8);
        end
        @(posedge Clk); #1;
        drive(0, 1'b0, 9'h0);
        n_cmp++;
        if (cnt8 !== 3'd1 || done8 !== 1'b1) begin
          n_err++;
          $display("FAIL pushpop_after count/done=%0d/%b, required 1/1", cnt8, done8);
        end
      end
    join
  endtask

  task automatic test_config_change;
    frame_t q[$];
    logic [8:0] w[$];
    set_cfg(4, 2'b00, 1'b0);
    w.push_back(9'h0E7); w.push_back(9'h03C);
    q.push_back(mk(9'h0E7, 4, 2'b00, 1'b0));
    q.push_back(mk(9'h03C, 2, 2'b10, 1'b0));
    fork
      push_words(0, w);
      check_frames(0, q);
      begin
        repeat (15) @(negedge Clk);
        parity_mode = 2'b10;
        baud_div    = 16'd2;
      end
    join
  endtask

  task automatic test_reset_mid;
    frame_t q[$];
    logic [8:0] w[$];
    int bad;
    set_cfg(4, 2'b00, 1'b0);
    w.push_back(9'h011); w.push_back(9'h022); w.push_back(9'h033);
    push_words(0, w);
    repeat (10) @(negedge Clk);
    n_cmp++;
    if (cnt8 !== 3'd2 || st8 !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset count/state=%0d/%b, required 2/1", cnt8, st8);
    end
    #2 Rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tx8, done8, st8, bus8.data_ready, cnt8} !== 7'b1001_000) begin
      n_err++;
      $display("FAIL async_reset tx/done/state/ready/count=%b%b%b%b/%0d, required 1001/0",
               tx8, done8, st8, bus8.data_ready, cnt8);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge Clk);
      if (tx8 !== 1'b1 || st8 !== 1'b0 || cnt8 !== 3'd0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL post_reset_idle: %0d non-idle cycles, required 0", bad);
    end
    w.delete();
    w.push_back(9'h05A);
    q.push_back(mk(9'h05A, 4, 2'b00, 1'b0));
    fork
      push_words(0, w);
      check_frames(0, q);
    join
  endtask

  task automatic test_random;
    frame_t q[$];
    logic [8:0] w[$];
    logic [8:0] v;
    int dut, dv, n;
    logic [1:0] pm;
    logic s2;
    for (int it = 0; it < 10; it++) begin
      dut = int'($urandom_range(0, 1));
      dv  = int'($urandom_range(0, 4));
      pm  = 2'($urandom_range(0, 3));
      s2  = 1'($urandom_range(0, 1));
      n   = int'($urandom_range(1, 4));
      set_cfg(dv, pm, s2);
      q.delete(); w.delete();
      for (int i = 0; i < n; i++) begin
        v = 9'($urandom_range(0, 511)) & ((dut == 0) ? 9'h0FF : 9'h07F);
        w.push_back(v);
        q.push_back(mk(v, dv, pm, s2));
      end
      fork
        push_words(dut, w);
        check_frames(dut, q);
      join
    end
  endtask

  initial begin
    test_reset;
    test_8n1_latency;
    test_parity7;
    test_back_to_back;
    test_push_pop;
    test_config_change;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
